// File: rtl/mem_port_arbiter_if.sv
// Request/grant, memory bus and read-return signals between the core-side requesters and the memory port arbiter.
// Purely a signal bundle; carries no state and adds no latency.
// Backpressure is expressed by mem2proc_response == 0 (refusal) and by the per-requester gnt pulses.
interface mem_port_arbiter_if;
   // store requester
   logic        st_req;
   logic [31:0] st_addr;
   logic [63:0] st_data;
   logic [1:0]  st_size;
   // load buffer requester
   logic        ld_req;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic [2:0]  ld_id;
   // fetch requester
   logic        if_req;
   logic [31:0] if_addr;
   // branch misprediction
   logic        squash;
   // acceptance pulses
   logic        st_gnt;
   logic        ld_gnt;
   logic        if_gnt;
   // memory command bus
   logic [1:0]  proc2mem_command;
   logic [31:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [1:0]  proc2mem_size;
   // memory response bus
   logic [3:0]  mem2proc_response;
   logic [63:0] mem2proc_data;
   logic [3:0]  mem2proc_tag;
   // read returns
   logic        ld_valid;
   logic [63:0] ld_data;
   logic [2:0]  ld_id_out;
   logic        if_valid;
   logic [63:0] if_data;
   // status
   logic        if_mem_hazard;
   logic        rd_busy;

   // arbiter side
   modport slave (
      input  st_req, st_addr, st_data, st_size,
      input  ld_req, ld_addr, ld_size, ld_id,
      input  if_req, if_addr, squash,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output st_gnt, ld_gnt, if_gnt,
      output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
      output ld_valid, ld_data, ld_id_out, if_valid, if_data,
      output if_mem_hazard, rd_busy
   );

   // requester / memory-model side
   modport master (
      output st_req, st_addr, st_data, st_size,
      output ld_req, ld_addr, ld_size, ld_id,
      output if_req, if_addr, squash,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  st_gnt, ld_gnt, if_gnt,
      input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
      input  ld_valid, ld_data, ld_id_out, if_valid, if_data,
      input  if_mem_hazard, rd_busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between store, load and fetch; tracks a single outstanding read and routes its return.
// Request to command/grant is combinational (0 cycles); read data appears 1 cycle after the matching tag.
// A refused request (response 0) is simply re-arbitrated next cycle; reads are blocked while one is outstanding.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_WAIT    = 1'b1;
   localparam logic [1:0] CMD_NONE  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_STORE = 2'd2;
   localparam logic [1:0] SEL_NONE  = 2'd0;
   localparam logic [1:0] SEL_ST    = 2'd1;
   localparam logic [1:0] SEL_LD    = 2'd2;
   localparam logic [1:0] SEL_IF    = 2'd3;
   localparam logic       OWN_LD    = 1'b0;
   localparam logic       OWN_IF    = 1'b1;
   // fetch carries no size of its own; it always reads a full doubleword
   localparam logic [1:0] IF_SIZE   = 2'd3;
   localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

   logic [0:0] state;
   logic [3:0] rd_tag;
   logic       rd_owner;
   logic [2:0] rd_id;
   logic       rd_kill;
   logic [3:0] starve_cnt;
   logic [1:0] sel;
   logic       accepted;
   logic       rd_accept;
   logic       rd_return;
   logic       deliver;

   // Choose one requester; while a read is outstanding only stores may use the port.
   always_comb begin
      sel = SEL_NONE;
      if (reset) begin
         sel = SEL_NONE;
      end else if (state == S_WAIT) begin
         if (bus.st_req) sel = SEL_ST;
      end else if (bus.if_req && starve_cnt == LIMIT) begin
         sel = SEL_IF;
      end else if (bus.st_req) begin
         sel = SEL_ST;
      end else if (bus.ld_req) begin
         sel = SEL_LD;
      end else if (bus.if_req) begin
         sel = SEL_IF;
      end
   end

   assign accepted  = (sel != SEL_NONE) && (bus.mem2proc_response != 4'd0);
   assign rd_accept = accepted && (sel == SEL_LD || sel == SEL_IF);
   // a tag is only looked at once we are already waiting, so a same-cycle match at acceptance is ignored
   assign rd_return = (state == S_WAIT) && (bus.mem2proc_tag == rd_tag) && (bus.mem2proc_tag != 4'd0);
   // a squash arriving together with the return still cancels delivery
   assign deliver   = rd_return && !(rd_kill || bus.squash);

   assign bus.st_gnt        = accepted && (sel == SEL_ST);
   assign bus.ld_gnt        = accepted && (sel == SEL_LD);
   assign bus.if_gnt        = accepted && (sel == SEL_IF);
   assign bus.if_mem_hazard = !reset && bus.if_req && !bus.if_gnt;
   assign bus.rd_busy       = (state == S_WAIT);

   // Present the selected requester on the memory command bus.
   always_comb begin
      bus.proc2mem_command = CMD_NONE;
      bus.proc2mem_addr    = 32'd0;
      bus.proc2mem_data    = 64'd0;
      bus.proc2mem_size    = 2'd0;
      case (sel)
         SEL_ST: begin
            bus.proc2mem_command = CMD_STORE;
            bus.proc2mem_addr    = bus.st_addr;
            bus.proc2mem_data    = bus.st_data;
            bus.proc2mem_size    = bus.st_size;
         end
         SEL_LD: begin
            bus.proc2mem_command = CMD_LOAD;
            bus.proc2mem_addr    = bus.ld_addr;
            bus.proc2mem_size    = bus.ld_size;
         end
         SEL_IF: begin
            bus.proc2mem_command = CMD_LOAD;
            bus.proc2mem_addr    = bus.if_addr;
            bus.proc2mem_size    = IF_SIZE;
         end
         default: ;
      endcase
   end

   // Outstanding-read tracker: capture tag/owner on acceptance, release on the matching return.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         rd_tag   <= 4'd0;
         rd_owner <= OWN_LD;
         rd_id    <= 3'd0;
         rd_kill  <= 1'b0;
      end else if (state == S_IDLE) begin
         if (rd_accept) begin
            state    <= S_WAIT;
            rd_tag   <= bus.mem2proc_response;
            rd_owner <= (sel == SEL_IF) ? OWN_IF : OWN_LD;
            rd_id    <= bus.ld_id;
            rd_kill  <= bus.squash;
         end
      end else begin
         if (rd_return) begin
            state   <= S_IDLE;
            rd_kill <= 1'b0;
         end else if (bus.squash) begin
            rd_kill <= 1'b1;
         end
      end
   end

   // Count consecutive cycles fetch asks and is turned away, saturating at the promotion point.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (!bus.if_req || bus.if_gnt) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Register the returning read toward its owner for one cycle; data is zero otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.ld_valid  <= 1'b0;
         bus.ld_data   <= 64'd0;
         bus.ld_id_out <= 3'd0;
         bus.if_valid  <= 1'b0;
         bus.if_data   <= 64'd0;
      end else begin
         bus.ld_valid  <= deliver && (rd_owner == OWN_LD);
         bus.ld_data   <= (deliver && rd_owner == OWN_LD) ? bus.mem2proc_data : 64'd0;
         bus.ld_id_out <= (deliver && rd_owner == OWN_LD) ? rd_id : 3'd0;
         bus.if_valid  <= deliver && (rd_owner == OWN_IF);
         bus.if_data   <= (deliver && rd_owner == OWN_IF) ? bus.mem2proc_data : 64'd0;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized plus directed checking of mem_port_arbiter against a queue-based reference model.
// Inputs change just after the falling edge; outputs are sampled 2 time units later.
// Memory refusal is exercised by random zero responses.
module tb_mem_port_arbiter;
   localparam int LIMIT = 8;

   logic clock;
   logic reset;
   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      bit         is_if;
      logic [3:0] tag;
      logic [2:0] id;
      bit         dead;
   } rd_t;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   rd_t         outstanding[$];
   int          starve = 0;
   logic        e_ld_valid = 1'b0;
   logic [63:0] e_ld_data  = 64'd0;
   logic [2:0]  e_ld_id    = 3'd0;
   logic        e_if_valid = 1'b0;
   logic [63:0] e_if_data  = 64'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_idle();
      bus.st_req = 1'b0; bus.st_addr = 32'd0; bus.st_data = 64'd0; bus.st_size = 2'd0;
      bus.ld_req = 1'b0; bus.ld_addr = 32'd0; bus.ld_size = 2'd0; bus.ld_id = 3'd0;
      bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.squash = 1'b0;
      bus.mem2proc_response = 4'd0; bus.mem2proc_data = 64'd0; bus.mem2proc_tag = 4'd0;
   endtask

   // Check one cycle against the model, advance the model, move to the next falling edge.
   task automatic run_cycle();
      int          win;
      bit          acc;
      bit          returned;
      rd_t         r;
      logic [1:0]  e_cmd;
      logic [31:0] e_addr;
      logic [63:0] e_data;
      logic [1:0]  e_size;
      #2;
      win = 0;
      if (outstanding.size() == 0) begin
         if (bus.if_req && starve == LIMIT) win = 3;
         else if (bus.st_req) win = 1;
         else if (bus.ld_req) win = 2;
         else if (bus.if_req) win = 3;
      end else if (bus.st_req) begin
         win = 1;
      end
      acc = (win != 0) && (bus.mem2proc_response != 4'd0);
      e_cmd = 2'd0; e_addr = 32'd0; e_data = 64'd0; e_size = 2'd0;
      if (win == 1) begin e_cmd = 2'd2; e_addr = bus.st_addr; e_data = bus.st_data; e_size = bus.st_size; end
      if (win == 2) begin e_cmd = 2'd1; e_addr = bus.ld_addr; e_size = bus.ld_size; end
      if (win == 3) begin e_cmd = 2'd1; e_addr = bus.if_addr; e_size = 2'd3; end

      chk("st_gnt", bus.st_gnt, acc && win == 1);
      chk("ld_gnt", bus.ld_gnt, acc && win == 2);
      chk("if_gnt", bus.if_gnt, acc && win == 3);
      chk("cmd", bus.proc2mem_command, e_cmd);
      chk("addr", bus.proc2mem_addr, e_addr);
      chk("data", bus.proc2mem_data, e_data);
      chk("size", bus.proc2mem_size, e_size);
      chk("hazard", bus.if_mem_hazard, bus.if_req && !(acc && win == 3));
      chk("rd_busy", bus.rd_busy, outstanding.size() != 0);
      chk("ld_valid", bus.ld_valid, e_ld_valid);
      chk("ld_data", bus.ld_data, e_ld_data);
      chk("ld_id_out", bus.ld_id_out, e_ld_id);
      chk("if_valid", bus.if_valid, e_if_valid);
      chk("if_data", bus.if_data, e_if_data);

      returned = 1'b0;
      r = '{is_if: 1'b0, tag: 4'd0, id: 3'd0, dead: 1'b0};
      if (outstanding.size() != 0) begin
         r = outstanding.pop_front();
         if (bus.squash) r.dead = 1'b1;
         if (bus.mem2proc_tag != 4'd0 && bus.mem2proc_tag == r.tag) returned = 1'b1;
         else outstanding.push_front(r);
      end else if (acc && win >= 2) begin
         outstanding.push_back('{is_if: (win == 3), tag: bus.mem2proc_response,
                                 id: bus.ld_id, dead: bus.squash});
      end
      e_ld_valid = returned && !r.is_if && !r.dead;
      e_ld_data  = e_ld_valid ? bus.mem2proc_data : 64'd0;
      e_ld_id    = e_ld_valid ? r.id : 3'd0;
      e_if_valid = returned && r.is_if && !r.dead;
      e_if_data  = e_if_valid ? bus.mem2proc_data : 64'd0;
      if (bus.if_req && !(acc && win == 3)) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      @(negedge clock);
   endtask

   // Assert reset with requests active; everything must read inactive, then release.
   task automatic apply_reset();
      reset = 1'b1;
      bus.st_req = 1'b1; bus.ld_req = 1'b1; bus.if_req = 1'b1; bus.mem2proc_response = 4'd5;
      #1;
      chk("rst_st_gnt", bus.st_gnt, 1'b0);
      chk("rst_ld_gnt", bus.ld_gnt, 1'b0);
      chk("rst_if_gnt", bus.if_gnt, 1'b0);
      chk("rst_cmd", bus.proc2mem_command, 2'd0);
      chk("rst_addr", bus.proc2mem_addr, 32'd0);
      chk("rst_hazard", bus.if_mem_hazard, 1'b0);
      chk("rst_busy", bus.rd_busy, 1'b0);
      chk("rst_ld_valid", bus.ld_valid, 1'b0);
      chk("rst_ld_data", bus.ld_data, 64'd0);
      chk("rst_if_valid", bus.if_valid, 1'b0);
      chk("rst_if_data", bus.if_data, 64'd0);
      outstanding.delete();
      starve = 0;
      e_ld_valid = 1'b0; e_ld_data = 64'd0; e_ld_id = 3'd0;
      e_if_valid = 1'b0; e_if_data = 64'd0;
      @(negedge clock);
      reset = 1'b0;
      set_idle();
   endtask

   initial begin
      reset = 1'b0;
      set_idle();
      @(negedge clock);
      apply_reset();

      // all three requesting: store wins, fetch sees a hazard, no read outstanding
      set_idle();
      bus.st_req = 1'b1; bus.ld_req = 1'b1; bus.if_req = 1'b1; bus.mem2proc_response = 4'd5;
      bus.st_addr = 32'h0000_0200; bus.st_data = 64'h1111_2222_3333_4444; bus.st_size = 2'd3;
      #1;
      chk("s1_st_gnt", bus.st_gnt, 1'b1);
      chk("s1_cmd", bus.proc2mem_command, 2'd2);
      chk("s1_hazard", bus.if_mem_hazard, 1'b1);
      run_cycle();
      set_idle(); #1;
      chk("s1_busy", bus.rd_busy, 1'b0);
      run_cycle();

      // load accepted with tag 7, returns three cycles later
      bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_id = 3'd3; bus.ld_size = 2'd2;
      bus.mem2proc_response = 4'd7;
      #1;
      chk("s2_ld_gnt", bus.ld_gnt, 1'b1);
      chk("s2_addr", bus.proc2mem_addr, 32'h100);
      run_cycle();
      set_idle(); run_cycle();
      set_idle(); run_cycle();
      bus.mem2proc_tag = 4'd7; bus.mem2proc_data = 64'hDEAD;
      run_cycle();
      set_idle(); #1;
      chk("s2_ld_valid", bus.ld_valid, 1'b1);
      chk("s2_ld_data", bus.ld_data, 64'hDEAD);
      chk("s2_ld_id", bus.ld_id_out, 3'd3);
      chk("s2_busy", bus.rd_busy, 1'b0);
      run_cycle();
      #1;
      chk("s2_ld_valid_once", bus.ld_valid, 1'b0);
      run_cycle();

      // fetch starved by continuous stores is promoted on its 9th request cycle
      for (int i = 1; i <= 9; i++) begin
         bus.st_req = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h8000; bus.mem2proc_response = 4'd1;
         #1;
         chk($sformatf("s3_if_gnt_%0d", i), bus.if_gnt, (i == 9));
         run_cycle();
      end
      set_idle(); bus.mem2proc_tag = 4'd1; bus.mem2proc_data = 64'hF00D;
      run_cycle();
      set_idle(); bus.st_req = 1'b1; bus.if_req = 1'b1; bus.mem2proc_response = 4'd2;
      #1;
      chk("s3_if_valid", bus.if_valid, 1'b1);
      chk("s3_cnt_cleared", bus.st_gnt, 1'b1);
      run_cycle();
      set_idle(); run_cycle();

      // squashed fetch: return exits WAIT silently, load then proceeds
      bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.mem2proc_response = 4'd2;
      #1;
      chk("s4_if_gnt", bus.if_gnt, 1'b1);
      run_cycle();
      set_idle(); bus.squash = 1'b1; run_cycle();
      set_idle(); bus.mem2proc_tag = 4'd2; bus.mem2proc_data = 64'hBEEF; run_cycle();
      set_idle(); bus.ld_req = 1'b1; bus.ld_id = 3'd1; bus.mem2proc_response = 4'd3;
      #1;
      chk("s4_if_valid", bus.if_valid, 1'b0);
      chk("s4_busy", bus.rd_busy, 1'b0);
      chk("s4_ld_gnt", bus.ld_gnt, 1'b1);
      run_cycle();
      set_idle(); bus.mem2proc_tag = 4'd3; run_cycle();
      set_idle(); run_cycle();

      // memory refuses three times, then accepts
      for (int i = 0; i < 4; i++) begin
         bus.ld_req = 1'b1; bus.ld_addr = 32'h300; bus.mem2proc_response = (i == 3) ? 4'd4 : 4'd0;
         #1;
         chk($sformatf("s5_ld_gnt_%0d", i), bus.ld_gnt, (i == 3));
         chk($sformatf("s5_cmd_%0d", i), bus.proc2mem_command, 2'd1);
         run_cycle();
      end
      set_idle(); bus.mem2proc_tag = 4'd4; run_cycle();
      set_idle(); run_cycle();

      // reset in the middle of a WAIT drops the read
      bus.ld_req = 1'b1; bus.ld_id = 3'd5; bus.mem2proc_response = 4'd9;
      run_cycle();
      set_idle(); run_cycle();
      apply_reset();
      bus.mem2proc_tag = 4'd9; bus.mem2proc_data = 64'h1234;
      run_cycle();
      set_idle(); #1;
      chk("s6_ld_valid", bus.ld_valid, 1'b0);
      chk("s6_ld_data", bus.ld_data, 64'd0);
      chk("s6_busy", bus.rd_busy, 1'b0);
      run_cycle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (i == 300) apply_reset();
         bus.st_req  = ($urandom_range(0, 2) == 0);
         bus.ld_req  = ($urandom_range(0, 1) == 0);
         bus.if_req  = ($urandom_range(0, 1) == 0);
         bus.st_addr = $urandom; bus.st_data = {$urandom, $urandom}; bus.st_size = 2'($urandom_range(0, 3));
         bus.ld_addr = $urandom; bus.ld_size = 2'($urandom_range(0, 3)); bus.ld_id = 3'($urandom_range(0, 7));
         bus.if_addr = $urandom;
         bus.squash  = ($urandom_range(0, 9) == 0);
         bus.mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         bus.mem2proc_data = {$urandom, $urandom};
         if (outstanding.size() != 0 && $urandom_range(0, 2) == 0) bus.mem2proc_tag = outstanding[0].tag;
         else bus.mem2proc_tag = 4'($urandom_range(0, 15));
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
